// File: rtl/sme_pkg.sv
// Shared constants and FSM state type for the SME record feeder.
package sme_pkg;

  localparam int unsigned STR_MAX = 32;
  localparam int unsigned PAT_MAX = 8;
  localparam int unsigned TIMEOUT = 64;

  localparam logic [7:0] META_ANCHOR = 8'h5E;  // '^'
  localparam logic [7:0] META_END    = 8'h24;  // '$'
  localparam logic [7:0] META_ANY    = 8'h2E;  // '.'

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StSendStr,
    StSendPat,
    StWaitRes
  } state_e;

endpackage

// File: rtl/sme_byte_buf.sv
// Record byte store: synchronous write, combinational read by index.
module sme_byte_buf #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sme_feeder.sv
// Buffers one host record (string or pattern), replays it to the SME, and for
// patterns waits for the SME result strobe with a timeout.
module sme_feeder
  import sme_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_kind,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       err
);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] len_q, len_d;
  logic [5:0] tmo_q, tmo_d;
  logic       kind_q, kind_d;
  logic       drop_q, drop_d;
  logic       sent_q, sent_d;
  logic       err_q, err_d;
  logic       live_q;
  logic       acc, cur_kind, buf_we;
  logic [5:0] max_len;
  logic [7:0] buf_rdata;

  // in_ready stays low until the first edge after reset release.
  assign in_ready = live_q && ((state_q == StIdle) || (state_q == StRecv));
  assign acc      = in_valid && in_ready;
  assign cur_kind = (state_q == StIdle) ? in_kind : kind_q;
  assign max_len  = cur_kind ? 6'(PAT_MAX) : 6'(STR_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    kind_d  = kind_q;
    drop_d  = drop_q;
    sent_d  = sent_q;
    err_d   = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      StIdle, StRecv: begin
        if (acc) begin
          if (state_q == StIdle) kind_d = in_kind;
          if (drop_q) begin
            if (in_last) begin
              drop_d  = 1'b0;
              cnt_d   = '0;
              state_d = StIdle;
            end
          end else if (cnt_q == max_len) begin
            err_d = 1'b1;
            cnt_d = '0;
            if (in_last) begin
              state_d = StIdle;
            end else begin
              drop_d  = 1'b1;
              state_d = StRecv;
            end
          end else begin
            buf_we = 1'b1;
            if (in_last) begin
              len_d = cnt_q + 6'd1;
              cnt_d = '0;
              if (!cur_kind) begin
                state_d = StSendStr;
                sent_d  = 1'b1;
              end else if (sent_q) begin
                state_d = StSendPat;
              end else begin
                err_d   = 1'b1;
                state_d = StIdle;
              end
            end else begin
              cnt_d   = cnt_q + 6'd1;
              state_d = StRecv;
            end
          end
        end
      end
      StSendStr: begin
        if (cnt_q == len_q - 6'd1) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StSendPat: begin
        if (cnt_q == len_q - 6'd1) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = StWaitRes;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StWaitRes: begin
        if (sme_valid) begin
          tmo_d   = '0;
          state_d = StIdle;
        end else if (tmo_q == 6'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      kind_q  <= 1'b0;
      drop_q  <= 1'b0;
      sent_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      kind_q  <= kind_d;
      drop_q  <= drop_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  sme_byte_buf #(
    .Depth(STR_MAX),
    .Width(8)
  ) u_buf (
    .clk_i  (clk),
    .we_i   (buf_we),
    .waddr_i(cnt_q[4:0]),
    .wdata_i(in_data),
    .raddr_i(cnt_q[4:0]),
    .rdata_o(buf_rdata)
  );

  assign isstring  = (state_q == StSendStr);
  assign ispattern = (state_q == StSendPat);
  assign chardata  = (isstring || ispattern) ? buf_rdata : 8'h00;
  assign busy      = (state_q == StSendStr) || (state_q == StSendPat) || (state_q == StWaitRes);
  assign err       = err_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Self-checking bench for sme_feeder: directed scenarios plus randomized records
// checked against a record-level reference model.
`timescale 1ns/1ps
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_kind = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid = 1'b0;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  sme_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_kind  (in_kind),
    .in_last  (in_last),
    .in_ready (in_ready),
    .chardata (chardata),
    .isstring (isstring),
    .ispattern(ispattern),
    .sme_valid(sme_valid),
    .busy     (busy),
    .err      (err)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rec_q[$];
  logic [7:0] str_seen[$];
  logic [7:0] pat_seen[$];
  int         err_cnt = 0;
  int         viol_cnt = 0;
  int         stall_cnt = 0;
  bit         model_sent = 1'b0;

  // Output monitor: collects replayed bytes, err pulses and output-rule violations.
  always @(negedge clk) begin
    if (reset) begin
      if (isstring) str_seen.push_back(chardata);
      if (ispattern) pat_seen.push_back(chardata);
      if (err) err_cnt++;
      if (isstring && ispattern) viol_cnt++;
      if (!isstring && !ispattern && chardata !== 8'h00) viol_cnt++;
    end
  end

  task automatic drive_record(input logic kind, input int gap_max, input bit rand_smev);
    int gap;
    int guard;
    stall_cnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < rec_q.size(); i++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_data   = rec_q[i];
      in_kind   = kind;
      in_last   = (i == rec_q.size() - 1);
      sme_valid = rand_smev ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 200) begin
        stall_cnt++;
        guard++;
        @(negedge clk);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL handshake byte %0d: in_ready=%b required 1 within 200 cycles", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      sme_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, busy, isstring, ispattern, err, chardata} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {in_ready, busy, isstring, ispattern, err, chardata});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_pat_first();
    int eb;
    rec_q = '{8'h5E, 8'h61, 8'h62};
    str_seen.delete(); pat_seen.delete(); eb = err_cnt;
    drive_record(1'b1, 0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (pat_seen.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pat_first_drop: pat bytes=%0d busy=%b required 0/0", pat_seen.size(), busy);
    end
    checks++;
    if (err_cnt - eb != 1) begin
      errors++;
      $display("FAIL pat_first_err: err pulses=%0d required 1", err_cnt - eb);
    end
  endtask

  task automatic test_string();
    logic [7:0] exp_b[3];
    exp_b = '{8'h61, 8'h62, 8'h63};
    rec_q = '{8'h61, 8'h62, 8'h63};
    drive_record(1'b0, 0, 1'b0);
    model_sent = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (i < 3) begin
        if (isstring !== 1'b1 || chardata !== exp_b[i] || busy !== 1'b1 || ispattern !== 1'b0) begin
          errors++;
          $display("FAIL str_abc cyc %0d: isstring=%b data=%h busy=%b required 1/%h/1",
                   i, isstring, chardata, busy, exp_b[i]);
        end
      end else if (isstring !== 1'b0 || busy !== 1'b0 || chardata !== 8'h00) begin
        errors++;
        $display("FAIL str_abc end: isstring=%b busy=%b data=%h required 0/0/00",
                 isstring, busy, chardata);
      end
    end
  endtask

  task automatic test_pattern();
    logic [7:0] exp_b[3];
    int eb;
    exp_b = '{8'h5E, 8'h61, 8'h62};
    rec_q = '{8'h5E, 8'h61, 8'h62};
    eb = err_cnt;
    drive_record(1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ispattern !== 1'b1 || chardata !== exp_b[i] || busy !== 1'b1 || isstring !== 1'b0) begin
        errors++;
        $display("FAIL pat_send cyc %0d: ispattern=%b data=%h busy=%b required 1/%h/1",
                 i, ispattern, chardata, busy, exp_b[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (ispattern !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pat_wait_enter: ispattern=%b busy=%b required 0/1", ispattern, busy);
    end
    repeat (5) @(posedge clk);
    #1 sme_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pat_busy_at_valid: busy=%b required 1", busy);
    end
    @(posedge clk); #1 sme_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_cnt != eb) begin
      errors++;
      $display("FAIL pat_release: busy=%b err pulses=%0d required 0/0", busy, err_cnt - eb);
    end
  endtask

  task automatic test_timeout();
    int first_err;
    bit busy_at[71];
    rec_q = '{8'h61, 8'h2E, 8'h62};
    drive_record(1'b1, 0, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    first_err = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      busy_at[k] = busy;
      if (err === 1'b1 && first_err < 0) first_err = k;
    end
    checks++;
    if (first_err != 64) begin
      errors++;
      $display("FAIL timeout_err_cycle: err at %0d required 64", first_err);
    end
    checks++;
    if (busy_at[63] !== 1'b1 || busy_at[64] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy: busy@63=%b busy@64=%b required 1/0", busy_at[63], busy_at[64]);
    end
  endtask

  task automatic test_overlength();
    int eb;
    rec_q.delete();
    for (int i = 0; i < 33; i++) rec_q.push_back(8'h41 + 8'(i % 26));
    str_seen.delete(); eb = err_cnt;
    drive_record(1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (str_seen.size() != 0 || err_cnt - eb != 1) begin
      errors++;
      $display("FAIL overlength: string bytes=%0d err pulses=%0d required 0/1",
               str_seen.size(), err_cnt - eb);
    end
    checks++;
    if (stall_cnt != 0) begin
      errors++;
      $display("FAIL overlength_ready: stall cycles=%0d required 0", stall_cnt);
    end
  endtask

  task automatic test_reset_midsend();
    rec_q.delete();
    for (int i = 0; i < 10; i++) rec_q.push_back(8'h30 + 8'(i));
    drive_record(1'b0, 0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++;
    if ({isstring, busy, in_ready, err, chardata} !== 12'h0) begin
      errors++;
      $display("FAIL midsend_reset: got %b required all zero",
               {isstring, busy, in_ready, err, chardata});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_sent = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midsend_ready: in_ready=%b required 1", in_ready);
    end
    rec_q = '{8'h5A};
    str_seen.delete(); pat_seen.delete();
    drive_record(1'b0, 0, 1'b0);
    model_sent = 1'b1;
    @(negedge clk);
    checks++;
    if (isstring !== 1'b1 || chardata !== 8'h5A) begin
      errors++;
      $display("FAIL post_reset_str: isstring=%b data=%h required 1/5a", isstring, chardata);
    end
    @(negedge clk);
    checks++;
    if (isstring !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_end: isstring=%b busy=%b required 0/0", isstring, busy);
    end
  endtask

  task automatic test_random();
    logic       kind;
    int         len, maxl, delay, eb, vb, exp_errs, guard;
    bit         dispatch, timeout, ok;
    logic [7:0] exp_str[$];
    logic [7:0] exp_pat[$];
    for (int r = 0; r < 40; r++) begin
      kind = 1'($urandom_range(0, 1));
      len  = kind ? $urandom_range(1, 10) : $urandom_range(1, 36);
      rec_q.delete();
      for (int i = 0; i < len; i++) rec_q.push_back(8'($urandom));
      maxl = kind ? 8 : 32;
      exp_str.delete(); exp_pat.delete();
      exp_errs = 0; dispatch = 1'b0; timeout = 1'b0;
      if (len > maxl) exp_errs = 1;
      else if (kind && !model_sent) exp_errs = 1;
      else begin
        dispatch = 1'b1;
        if (kind) exp_pat = rec_q;
        else begin
          exp_str = rec_q;
          model_sent = 1'b1;
        end
      end
      if (dispatch && kind && $urandom_range(0, 7) == 0) begin
        timeout  = 1'b1;
        exp_errs = 1;
      end
      delay = $urandom_range(0, 10);
      str_seen.delete(); pat_seen.delete();
      eb = err_cnt; vb = viol_cnt;
      drive_record(kind, 2, 1'b1);
      if (dispatch && kind) begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (ispattern && guard < 50);
        if (!timeout) begin
          repeat (delay) @(posedge clk);
          #1 sme_valid = 1'b1;
          @(posedge clk); #1 sme_valid = 1'b0;
        end
      end
      guard = 0;
      while (busy !== 1'b0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d idle: busy=%b required 0", r, busy);
      end
      ok = (str_seen.size() == exp_str.size());
      if (ok) foreach (exp_str[i]) if (str_seen[i] !== exp_str[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd%0d string: %0d bytes required %0d", r, str_seen.size(), exp_str.size());
      end
      ok = (pat_seen.size() == exp_pat.size());
      if (ok) foreach (exp_pat[i]) if (pat_seen[i] !== exp_pat[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd%0d pattern: %0d bytes required %0d", r, pat_seen.size(), exp_pat.size());
      end
      checks++;
      if (err_cnt - eb != exp_errs || viol_cnt != vb) begin
        errors++;
        $display("FAIL rnd%0d err: pulses=%0d violations=%0d required %0d/0",
                 r, err_cnt - eb, viol_cnt - vb, exp_errs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pat_first();
    test_string();
    test_pattern();
    test_timeout();
    test_overlength();
    test_reset_midsend();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
